shake_squeeze_collector: RTL and testbench

- Sits directly downstream of the SHAKE core and consumes its squeezed output stream (dout / dout_valid / dout_ready).
- Packs WIN_W-bit squeeze words into OUT_W-bit result words and counts them against a requested output length.
- Pulses force_done back to the core once the requested length is delivered, so the core stops squeezing.
- Presents packed words to the consumer (seed expander, sampler) over a valid/ready handshake.

---
 rtl/shake_squeeze_collector_pkg.sv | 28 ++
 rtl/shake_squeeze_collector_packer.sv | 58 +++++
 rtl/shake_squeeze_collector.sv | 106 ++++++++++
 tb/tb_shake_squeeze_collector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_squeeze_collector_pkg.sv
// Shared definitions for the SHAKE squeeze collector: FSM encoding, clog2 helper
// and default widths tied to the core output width (SHAKE_CORE_OUT_W).
`ifndef SHAKE_CORE_OUT_W
`define SHAKE_CORE_OUT_W 32
`endif

package shake_squeeze_collector_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FINISH  = 2'd2
  } state_e;

  localparam int DEF_WIN_W   = `SHAKE_CORE_OUT_W;
  localparam int DEF_OUT_W   = 128;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_RATIO   = DEF_OUT_W / DEF_WIN_W;
  localparam int DEF_PCNT_W  = clog2(DEF_RATIO + 1);

endpackage

// File: rtl/shake_squeeze_collector_packer.sv
// RATIO-slot shift/pack register: first pushed word ends up in the MSBs.
// SHAKE_COLLECT_BSWAP_EN byte-reverses each incoming word before packing.
module shake_word_packer
  import shake_squeeze_collector_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIN_W-1:0] i_word,
  input  logic             i_take,
  output logic             o_full,
  output logic             o_grp,
  output logic [OUT_W-1:0] o_grp_data
);
  localparam int P_RATIO = OUT_W / WIN_W;
  localparam int CNT_W   = clog2(P_RATIO + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_shifted;
  logic [WIN_W-1:0] w_word;
  logic             w_last;

`ifdef SHAKE_COLLECT_BSWAP_EN
  for (genvar b = 0; b < WIN_W/8; b++) begin : g_bswap
    assign w_word[8*b +: 8] = i_word[WIN_W-8-8*b +: 8];
  end
`else
  assign w_word = i_word;
`endif

  if (P_RATIO == 1) begin : g_single
    assign w_shifted = w_word;
  end else begin : g_multi
    assign w_shifted = {r_data[OUT_W-WIN_W-1:0], w_word};
  end

  assign o_full = (r_cnt == CNT_W'(P_RATIO));
  assign w_last = (r_cnt == CNT_W'(P_RATIO - 1));
  // The last word of a group can bypass straight to the consumer this cycle.
  assign o_grp      = o_full | (i_push & w_last);
  assign o_grp_data = o_full ? r_data : w_shifted;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      if (i_push) r_data <= w_shifted;
      if (i_take) r_cnt <= (o_full && i_push) ? CNT_W'(1) : '0;
      else if (i_push) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shake_squeeze_collector.sv
// Collects SHAKE squeeze words into OUT_W result words, counts them against the
// requested length and pulses force_done to stop the core. Optional: SHAKE_COLLECT_BSWAP_EN.
module shake_squeeze_collector
  import shake_squeeze_collector_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_out_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIN_W-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_force_done,
  output logic             o_busy,
  output logic             o_done
);
  localparam int P_RATIO = OUT_W / WIN_W;
  localparam int IW      = LEN_W + clog2(P_RATIO);

  state_e           r_state, w_next;
  logic [LEN_W-1:0] r_remaining;
  logic [IW-1:0]    r_issued, r_limit;
  logic [OUT_W-1:0] r_hold;
  logic             r_hold_v;
  logic             w_start, w_push, w_fire, w_take, w_hold_free;
  logic             w_full, w_grp;
  logic [OUT_W-1:0] w_grp_data;

  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_hold_free = !r_hold_v || i_out_ready;
  assign w_fire      = r_hold_v && i_out_ready;
  assign w_push      = i_in_valid && o_in_ready;
  assign w_take      = w_grp && w_hold_free;
  assign o_out_valid = r_hold_v;
  assign o_out_data  = r_hold;

  shake_word_packer #(.WIN_W(WIN_W), .OUT_W(OUT_W)) u_packer (
    .i_clk      (i_clk),
    .i_clr      (i_rst | w_start),
    .i_push     (w_push),
    .i_word     (i_in_data),
    .i_take     (w_take),
    .o_full     (w_full),
    .o_grp      (w_grp),
    .o_grp_data (w_grp_data)
  );

  always_comb begin
    w_next       = r_state;
    o_in_ready   = 1'b0;
    o_force_done = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = (i_out_len != '0) ? S_COLLECT : S_FINISH;
      S_COLLECT: begin
        o_busy = 1'b1;
        // Never accept beyond the requested length; a full packer may refill as it drains.
        o_in_ready = (!w_full || w_hold_free) && (r_issued < r_limit);
        if (w_fire && r_remaining == LEN_W'(1)) w_next = S_FINISH;
      end
      S_FINISH: begin
        o_busy       = 1'b1;
        o_force_done = 1'b1;
        o_done       = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_issued    <= '0;
      r_limit     <= '0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_remaining <= i_out_len;
        r_issued    <= '0;
        r_limit     <= IW'(i_out_len) * IW'(P_RATIO);
      end else begin
        if (w_push) r_issued <= r_issued + 1'b1;
        if (w_fire) r_remaining <= r_remaining - 1'b1;
      end
      if (w_take) begin
        r_hold   <= w_grp_data;
        r_hold_v <= 1'b1;
      end else if (w_fire) begin
        r_hold_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shake_squeeze_collector.sv
// Randomized self-checking bench for shake_squeeze_collector with a queue-based packing model.
module tb_shake_squeeze_collector;
  logic         i_clk = 1'b0;
  logic         i_rst, i_start, i_in_valid, i_out_ready;
  logic [15:0]  i_out_len;
  logic [31:0]  i_in_data;
  logic         o_in_ready, o_out_valid, o_force_done, o_busy, o_done;
  logic [127:0] o_out_data;

  shake_squeeze_collector #(.WIN_W(32), .OUT_W(128), .LEN_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_out_len(i_out_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_force_done(o_force_done), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, passes = 0, cyc = 0, done_n = 0;
  logic [31:0]  nd;
  logic [31:0]  acc_q[$];
  int           acc_cyc[$];
  logic [127:0] out_q[$];
  int           out_cyc[$];
  int           fd_cyc[$];

  function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef SHAKE_COLLECT_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Expected k-th packed word: four consecutive accepted words, earliest in the MSBs.
  function automatic logic [127:0] grp(input int k);
    if (acc_q.size() < 4*k + 4) return '0;
    return {xf(acc_q[4*k]), xf(acc_q[4*k+1]), xf(acc_q[4*k+2]), xf(acc_q[4*k+3])};
  endfunction

  task automatic clear_log();
    acc_q.delete(); acc_cyc.delete(); out_q.delete(); out_cyc.delete(); fd_cyc.delete();
    done_n = 0;
  endtask

  task automatic step(input bit st, input logic [15:0] len, input bit v,
                      input logic [31:0] d, input bit ordy, output bit acc);
    @(negedge i_clk);
    i_rst = 1'b0; i_start = st; i_out_len = len;
    i_in_valid = v; i_in_data = d; i_out_ready = ordy;
    #1;
    acc = v && o_in_ready;
    if (acc) begin acc_q.push_back(d); acc_cyc.push_back(cyc); end
    if (o_out_valid && ordy) begin out_q.push_back(o_out_data); out_cyc.push_back(cyc); end
    if (o_force_done) fd_cyc.push_back(cyc);
    if (o_done) done_n++;
    cyc++;
  endtask

  task automatic stream(input int budget, input int vpct, input int opct, input bit seq, output bit ok);
    bit a;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_n > 0) begin ok = 1'b1; break; end
      step(1'b0, 16'd0, $urandom_range(99) < vpct, nd, $urandom_range(99) < opct, a);
      if (a) nd = seq ? nd + 32'd1 : $urandom;
    end
    if (done_n > 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    checks++;
    if ({o_in_ready, o_out_valid, o_force_done, o_busy, o_done} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {o_in_ready, o_out_valid, o_force_done, o_busy, o_done});
    else passes++;
    checks++;
    if (o_out_data !== 128'h0) $display("FAIL reset_data: got %h want 0", o_out_data); else passes++;
  endtask

  task automatic test_basic();
    bit a, ok;
    clear_log(); nd = 32'd1;
    step(1'b1, 16'd2, 1'b0, 32'd0, 1'b1, a);
    stream(100, 100, 100, 1'b1, ok);
    repeat (3) step(1'b0, 16'd0, 1'b1, nd, 1'b1, a);
    checks++; if (!ok) $display("FAIL basic_timeout: got no done want done"); else passes++;
    checks++;
    if (out_q.size() != 2) $display("FAIL basic_out_count: got %0d want 2", out_q.size()); else passes++;
    for (int k = 0; k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== grp(k)) $display("FAIL basic_word%0d: got %h want %h", k, out_q[k], grp(k));
      else passes++;
    end
    checks++;
    if (acc_q.size() != 8) $display("FAIL basic_accepted: got %0d want 8", acc_q.size()); else passes++;
    checks++;
    if (fd_cyc.size() != 1 || out_cyc.size() != 2 || fd_cyc[0] != out_cyc[1] + 1)
      $display("FAIL basic_force_done: got %0d pulses want 1 pulse one cycle after last handshake", fd_cyc.size());
    else passes++;
    checks++;
    if (acc_cyc.size() < 4 || out_cyc.size() < 1 || out_cyc[0] != acc_cyc[3] + 1)
      $display("FAIL basic_latency: got out cycle %0d want one after 4th word", out_cyc.size() > 0 ? out_cyc[0] : -1);
    else passes++;
    checks++; if (done_n != 1) $display("FAIL basic_done: got %0d want 1", done_n); else passes++;
  endtask

  task automatic test_backpressure();
    bit a, ok;
    int bad;
    clear_log(); nd = $urandom; bad = 0;
    step(1'b1, 16'd2, 1'b0, 32'd0, 1'b0, a);
    for (int i = 0; i < 50 && !o_out_valid; i++) begin
      step(1'b0, 16'd0, 1'b1, nd, 1'b0, a);
      if (a) nd = $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'd0, 1'b1, nd, 1'b0, a);
      if (a) nd = $urandom;
      if (!o_out_valid || o_out_data !== grp(0)) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_stable: got %0d bad cycles want 0", bad); else passes++;
    checks++; if (acc_q.size() != 8) $display("FAIL bp_accepted: got %0d want 8", acc_q.size()); else passes++;
    checks++; if (o_in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", o_in_ready); else passes++;
    stream(100, 100, 100, 1'b0, ok);
    checks++; if (!ok) $display("FAIL bp_timeout: got no done want done"); else passes++;
    checks++;
    if (out_q.size() != 2) $display("FAIL bp_out_count: got %0d want 2", out_q.size()); else passes++;
    for (int k = 0; k < out_q.size(); k++) begin
      checks++;
      if (out_q[k] !== grp(k)) $display("FAIL bp_word%0d: got %h want %h", k, out_q[k], grp(k));
      else passes++;
    end
  endtask

  task automatic test_zero_len();
    bit a;
    int k;
    clear_log(); k = cyc;
    step(1'b1, 16'd0, 1'b1, $urandom, 1'b1, a);
    repeat (5) step(1'b0, 16'd0, 1'b1, $urandom, 1'b1, a);
    checks++; if (acc_q.size() != 0) $display("FAIL zero_in_ready: got %0d accepted want 0", acc_q.size()); else passes++;
    checks++;
    if (fd_cyc.size() != 1 || fd_cyc[0] != k + 1)
      $display("FAIL zero_force_done: got %0d pulses want 1 at cycle %0d", fd_cyc.size(), k + 1);
    else passes++;
    checks++; if (done_n != 1) $display("FAIL zero_done: got %0d want 1", done_n); else passes++;
  endtask

  task automatic test_gapped();
    bit a;
    clear_log(); nd = $urandom;
    step(1'b1, 16'd1, 1'b0, 32'd0, 1'b1, a);
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      step(1'b0, 16'd0, i[0], nd, 1'b1, a);
      if (a) nd = $urandom;
    end
    checks++;
    if (out_q.size() != 1 || out_q[0] !== grp(0))
      $display("FAIL gap_word: got %h want %h", out_q.size() > 0 ? out_q[0] : 128'h0, grp(0));
    else passes++;
    checks++;
    if (acc_cyc.size() != 4 || out_cyc.size() != 1 || out_cyc[0] != acc_cyc[3] + 1)
      $display("FAIL gap_latency: got %0d words %0d outs want 4 words, out one cycle later", acc_cyc.size(), out_cyc.size());
    else passes++;
  endtask

  task automatic test_midrun_reset();
    bit a, ok;
    clear_log(); nd = $urandom;
    step(1'b1, 16'd1, 1'b0, 32'd0, 1'b1, a);
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) begin
      step(1'b0, 16'd0, 1'b1, nd, 1'b1, a);
      if (a) nd = $urandom;
    end
    @(negedge i_clk);
    i_rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0; #1;
    checks++;
    if ({o_in_ready, o_out_valid, o_force_done, o_busy, o_done} !== 5'b0 || o_out_data !== 128'h0)
      $display("FAIL rst_outputs: got %b/%h want 00000/0",
               {o_in_ready, o_out_valid, o_force_done, o_busy, o_done}, o_out_data);
    else passes++;
    repeat (3) step(1'b0, 16'd0, 1'b1, nd, 1'b1, a);
    checks++; if (fd_cyc.size() != 0) $display("FAIL rst_no_force_done: got %0d want 0", fd_cyc.size()); else passes++;
    clear_log(); nd = $urandom;
    step(1'b1, 16'd1, 1'b0, 32'd0, 1'b1, a);
    stream(100, 100, 100, 1'b0, ok);
    checks++;
    if (!ok || out_q.size() != 1 || out_q[0] !== grp(0))
      $display("FAIL rst_restart: got %0d outs want 1 word %h", out_q.size(), grp(0));
    else passes++;
  endtask

  task automatic test_bswap();
    bit a;
    logic [127:0] exp;
`ifdef SHAKE_COLLECT_BSWAP_EN
    exp = {4{32'h44332211}};
`else
    exp = {4{32'h11223344}};
`endif
    clear_log();
    step(1'b1, 16'd1, 1'b0, 32'd0, 1'b1, a);
    for (int i = 0; i < 30 && done_n == 0; i++) step(1'b0, 16'd0, 1'b1, 32'h11223344, 1'b1, a);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== exp)
      $display("FAIL bswap_word: got %h want %h", out_q.size() > 0 ? out_q[0] : 128'h0, exp);
    else passes++;
  endtask

  task automatic test_random();
    bit a, ok;
    int len, bad;
    for (int it = 0; it < 8; it++) begin
      clear_log(); nd = $urandom; bad = 0;
      len = $urandom_range(4, 1);
      step(1'b1, 16'(len), 1'b0, 32'd0, 1'b1, a);
      stream(600, $urandom_range(100, 30), $urandom_range(100, 20), 1'b0, ok);
      checks++;
      if (!ok || out_q.size() != len || acc_q.size() != 4*len)
        $display("FAIL rand%0d_counts: got %0d outs %0d words want %0d outs", it, out_q.size(), acc_q.size(), len);
      else passes++;
      for (int k = 0; k < out_q.size(); k++) if (out_q[k] !== grp(k)) bad++;
      checks++; if (bad != 0) $display("FAIL rand%0d_data: got %0d bad words want 0", it, bad); else passes++;
      checks++;
      if (fd_cyc.size() != 1 || out_cyc.size() == 0 || fd_cyc[0] != out_cyc[out_cyc.size()-1] + 1)
        $display("FAIL rand%0d_force_done: got %0d pulses want 1 after last handshake", it, fd_cyc.size());
      else passes++;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_out_len = '0; i_in_valid = 1'b0;
    i_in_data = '0; i_out_ready = 1'b0; nd = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_gapped();
    test_midrun_reset();
    test_bswap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
